bin2bcd_seq: RTL and testbench

- Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Adds an explicit start/busy/done handshake, optional two's-complement signed input, a digit-count output for leading-zero blanking, and an overflow flag.
- Sits between the calculator arithmetic core and the display driver.

---
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 tb/tb_bin2bcd_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Start/busy/done handshake, optional signed input, digit count and overflow.
module bin2bcd_seq #(
  parameter int BWIDTH    = 32,
  parameter int DIGITS    = 10,
  parameter int SIGNED_EN = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BWIDTH-1:0]             bin_in,
  input  logic                          signed_in,
  output logic                          busy,
  output logic                          done,
  output logic [4*DIGITS-1:0]           bcd_out,
  output logic                          neg_out,
  output logic [$clog2(DIGITS+1)-1:0]   ndigits,
  output logic                          ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BWIDTH + 1);
  localparam int NW = $clog2(DIGITS + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]        state;
  logic [BWIDTH-1:0] mag;
  logic [BW-1:0]     work;
  logic [CW-1:0]     cnt;
  logic              neg_r;
  logic              ovf_acc;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic              out_bit;
  logic [NW-1:0]     nd;
  logic              neg_take;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = work[4*i +: 4];
    end
  end

  assign shifted = {adj[BW-2:0], mag[BWIDTH-1]};
  assign out_bit = adj[BW-1];

  // Highest nonzero digit of the final value; an all-zero result counts as one digit.
  always_comb begin
    nd = NW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[4*i +: 4] != 4'd0)
        nd = NW'(i + 1);
    end
  end

  assign neg_take = (SIGNED_EN != 0) && signed_in && bin_in[BWIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      neg_out <= 1'b0;
      ndigits <= NW'(1);
      ovf     <= 1'b0;
      mag     <= '0;
      work    <= '0;
      cnt     <= '0;
      neg_r   <= 1'b0;
      ovf_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mag     <= neg_take ? (~bin_in + 1'b1) : bin_in;
            neg_r   <= neg_take;
            work    <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(BWIDTH);
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          work    <= shifted;
          mag     <= mag << 1;
          cnt     <= cnt - CW'(1);
          ovf_acc <= ovf_acc | out_bit;
          if (cnt == CW'(1)) begin
            bcd_out <= shifted;
            neg_out <= neg_r;
            ndigits <= nd;
            ovf     <= ovf_acc | out_bit;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 32-bit/10-digit and 16-bit/4-digit builds.
// Expected results come from a divide-by-ten model through a scoreboard queue.
module tb_bin2bcd_seq;

  typedef struct {
    logic [63:0] bcd;
    logic        neg;
    int          nd;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_a = 1'b0;
  logic [31:0] bin_a = '0;
  logic        sgn_a = 1'b0;
  logic        busy_a, done_a, neg_a, ovf_a;
  logic [39:0] bcd_a;
  logic [3:0]  nd_a;

  logic        start_b = 1'b0;
  logic [15:0] bin_b = '0;
  logic        sgn_b = 1'b0;
  logic        busy_b, done_b, neg_b, ovf_b;
  logic [15:0] bcd_b;
  logic [2:0]  nd_b;

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BWIDTH(32), .DIGITS(10), .SIGNED_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .signed_in(sgn_a), .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
    .neg_out(neg_a), .ndigits(nd_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.BWIDTH(16), .DIGITS(4), .SIGNED_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .signed_in(sgn_b), .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
    .neg_out(neg_b), .ndigits(nd_b), .ovf(ovf_b)
  );

  function automatic exp_t model(logic [63:0] v, int bw, int dg, bit sgn);
    exp_t e;
    logic [63:0] mask;
    logic [63:0] m;
    mask = (bw == 64) ? '1 : ((64'd1 << bw) - 64'd1);
    v = v & mask;
    e.bcd = '0;
    e.neg = 1'b0;
    e.nd = 1;
    e.lat = bw;
    if (sgn && v[bw-1]) begin
      m = (~v + 64'd1) & mask;
      e.neg = 1'b1;
    end else begin
      m = v;
    end
    for (int i = 0; i < dg; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      if (m % 10 != 0) e.nd = i + 1;
      m = m / 10;
    end
    e.ovf = (m != 0);
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start now, accept on the next edge, then confirm busy.
  task automatic go(int which, logic [31:0] v, bit sgn);
    if (which == 0) begin
      start_a = 1'b1; bin_a = v; sgn_a = sgn;
      exp_q.push_back(model(64'(v), 32, 10, sgn));
    end else begin
      start_b = 1'b1; bin_b = v[15:0]; sgn_b = sgn;
      exp_q.push_back(model(64'(v[15:0]), 16, 4, sgn));
    end
    @(posedge clk); #1;
    check("busy_after_start", 64'(which == 0 ? busy_a : busy_b), 64'd1);
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a = 32'hDEADBEEF;
    bin_b = 16'hBEEF;
  endtask

  // Wait for done (bounded), optionally poking start mid-conversion.
  task automatic finish(int which, int poke);
    int   lat;
    logic d;
    exp_t e;
    lat = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == poke) begin
        start_a = (which == 0); start_b = (which != 0);
        bin_a = 32'd777; bin_b = 16'd777;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      d = (which == 0) ? done_a : done_b;
      if (d) break;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    e = exp_q.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    if (which == 0) begin
      check("bcd_a", 64'(bcd_a), e.bcd);
      check("neg_a", 64'(neg_a), 64'(e.neg));
      check("nd_a", 64'(nd_a), 64'(e.nd));
      check("ovf_a", 64'(ovf_a), 64'(e.ovf));
      check("busy_a_done", 64'(busy_a), 64'd0);
    end else begin
      check("bcd_b", 64'(bcd_b), e.bcd);
      check("neg_b", 64'(neg_b), 64'(e.neg));
      check("nd_b", 64'(nd_b), 64'(e.nd));
      check("ovf_b", 64'(ovf_b), 64'(e.ovf));
      check("busy_b_done", 64'(busy_b), 64'd0);
    end
  endtask

  task automatic quiet_a(string tag, int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done_a) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_bcd", 64'(bcd_a), 64'd0);
    check("rst_nd", 64'(nd_a), 64'd1);
    check("rst_neg_ovf", 64'({neg_a, ovf_a}), 64'd0);
    check("rst_nd_b", 64'(nd_b), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    go(0, 32'd0, 1'b0);          finish(0, 0);
    @(negedge clk);
    go(0, 32'hFFFFFFFF, 1'b0);   finish(0, 0);
    check("hex_ffffffff", 64'(bcd_a), 64'h4294967295);
    @(negedge clk);
    go(0, 32'hFFFFFFFF, 1'b1);   finish(0, 0);
    @(negedge clk);
    go(0, 32'h80000000, 1'b1);   finish(0, 0);
    check("most_negative", 64'(bcd_a), 64'h2147483648);
    @(negedge clk);
    go(0, 32'd5, 1'b1);          finish(0, 0);
    @(negedge clk);
    go(0, 32'hFFFFFF85, 1'b1);   finish(0, 0);

    // 123 with an ignored mid-conversion start, then 9876 in the done cycle.
    @(negedge clk);
    go(0, 32'd123, 1'b0);        finish(0, 12);
    go(0, 32'd9876, 1'b0);
    check("hold_during_conv", 64'(bcd_a), 64'h123);
    finish(0, 0);
    check("b2b_second", 64'(bcd_a), 64'h9876);
    quiet_a("no_extra_done", 40);

    // Reset mid-conversion.
    @(negedge clk);
    go(0, 32'd4321, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    void'(exp_q.pop_back());
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_done", 64'(done_a), 64'd0);
    check("abort_bcd", 64'(bcd_a), 64'd0);
    check("abort_nd", 64'(nd_a), 64'd1);
    quiet_a("abort_no_done", 40);
    @(negedge clk);
    go(0, 32'd1000000, 1'b0);    finish(0, 0);

    // Narrow build: overflow and its clearing.
    @(negedge clk);
    go(1, 32'd12345, 1'b0);      finish(1, 0);
    check("ovf_bcd_b", 64'(bcd_b), 64'h2345);
    @(negedge clk);
    go(1, 32'd99, 1'b0);         finish(1, 0);
    check("ovf_clear_b", 64'(ovf_b), 64'd0);
    @(negedge clk);
    go(1, 32'h8000, 1'b1);       finish(1, 0);
    @(negedge clk);
    go(1, 32'd9999, 1'b0);       finish(1, 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
